// File: rtl/mu0_pkg.sv
// Shared types and constants for the MU0 fetch/execute sequencer.
package mu0_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_e;

  // ALU function select driven onto the datapath.
  typedef enum logic [1:0] {
    PASSB = 2'd0,
    ADD   = 2'd1,
    SUB   = 2'd2,
    INC   = 2'd3
  } alu_fn_e;

  // Defined opcodes (IR[15:12]); 8-F are undefined.
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // True for opcodes that perform a data-memory access in EXECUTE.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STO) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_control.sv
// MU0 control sequencer: FETCH/EXECUTE/HALT state machine driving the
// datapath register enables, mux selects, ALU function and memory strobes.
module mu0_control
  import mu0_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_rdy,
  output logic       PC_En,
  output logic       IR_En,
  output logic       ACC_En,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fn,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted
);

  state_e state_q, state_d;

  // State register; reset returns the sequencer to FETCH at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (Mem_rdy) state_d = EXECUTE;
      end
      EXECUTE: begin
        if (is_mem_op(F)) begin
          if (Mem_rdy) state_d = FETCH;
        end else begin
          case (F)
            OP_JMP, OP_JGE, OP_JNE: state_d = FETCH;
            OP_STP:                 state_d = HALT;
            default:                state_d = HALT_ON_UNDEF ? HALT : FETCH;
          endcase
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; Reset gates every output so strobes drop asynchronously.
  always_comb begin
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    ACC_En   = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fn   = PASSB;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Halted   = 1'b0;
    if (Reset) begin
      case (state_q)
        FETCH: begin
          Addr_sel = 1'b0;
          Rd       = 1'b1;
          X_sel    = 1'b1;
          ALU_fn   = INC;
          IR_En    = Mem_rdy;
          PC_En    = Mem_rdy;
        end
        EXECUTE: begin
          Addr_sel = 1'b1;
          case (F)
            OP_LDA: begin
              Rd     = 1'b1;
              ALU_fn = PASSB;
              ACC_En = Mem_rdy;
            end
            OP_STO: begin
              Wr    = 1'b1;
              X_sel = 1'b0;
            end
            OP_ADD: begin
              Rd     = 1'b1;
              ALU_fn = ADD;
              ACC_En = Mem_rdy;
            end
            OP_SUB: begin
              Rd     = 1'b1;
              ALU_fn = SUB;
              ACC_En = Mem_rdy;
            end
            OP_JMP: begin
              Y_sel  = 1'b1;
              ALU_fn = PASSB;
              PC_En  = 1'b1;
            end
            OP_JGE: begin
              Y_sel  = 1'b1;
              ALU_fn = PASSB;
              PC_En  = ~N;
            end
            OP_JNE: begin
              Y_sel  = 1'b1;
              ALU_fn = PASSB;
              PC_En  = ~Z;
            end
            default: ;
          endcase
        end
        HALT:    Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: two instances (NOP and HALT handling
// of undefined opcodes) share stimulus; an independent cycle model pushes
// expected output vectors to a scoreboard that is popped after each drive.
`timescale 1ns/1ps
module tb_mu0_control;

  localparam int S_F = 0;
  localparam int S_E = 1;
  localparam int S_H = 2;

  logic       Clk, Reset, N, Z, Mem_rdy;
  logic [3:0] F;
  logic [10:0] o0, o1;

  logic pc0, ir0, acc0, xs0, ys0, as0, rd0, wr0, h0;
  logic pc1, ir1, acc1, xs1, ys1, as1, rd1, wr1, h1;
  logic [1:0] fn0, fn1;

  mu0_control #(.HALT_ON_UNDEF(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_rdy(Mem_rdy),
    .PC_En(pc0), .IR_En(ir0), .ACC_En(acc0), .X_sel(xs0), .Y_sel(ys0),
    .Addr_sel(as0), .ALU_fn(fn0), .Rd(rd0), .Wr(wr0), .Halted(h0)
  );

  mu0_control #(.HALT_ON_UNDEF(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_rdy(Mem_rdy),
    .PC_En(pc1), .IR_En(ir1), .ACC_En(acc1), .X_sel(xs1), .Y_sel(ys1),
    .Addr_sel(as1), .ALU_fn(fn1), .Rd(rd1), .Wr(wr1), .Halted(h1)
  );

  assign o0 = {pc0, ir0, acc0, xs0, ys0, as0, fn0, rd0, wr0, h0};
  assign o1 = {pc1, ir1, acc1, xs1, ys1, as1, fn1, rd1, wr1, h1};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [10:0] e0;
    logic [10:0] e1;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  st0 = S_F;
  int  st1 = S_F;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected vector {PC_En,IR_En,ACC_En,X_sel,Y_sel,Addr_sel,ALU_fn,Rd,Wr,Halted}.
  function automatic logic [10:0] exp_out(input int st, input logic [3:0] f,
                                          input logic n, input logic z,
                                          input logic rdy, input logic rst);
    logic pc, ir, acc, xs, ys, as_, rd, wr, h;
    logic [1:0] fn;
    {pc, ir, acc, xs, ys, as_, rd, wr, h} = '0;
    fn = 2'd0;
    if (rst) begin
      if (st == S_F) begin
        rd = 1'b1; xs = 1'b1; fn = 2'd3; ir = rdy; pc = rdy;
      end else if (st == S_H) begin
        h = 1'b1;
      end else begin
        as_ = 1'b1;
        if (f == 4'h0) begin
          rd = 1'b1; acc = rdy;
        end else if (f == 4'h1) begin
          wr = 1'b1;
        end else if (f == 4'h2 || f == 4'h3) begin
          rd = 1'b1; acc = rdy; fn = (f == 4'h2) ? 2'd1 : 2'd2;
        end else if (f >= 4'h4 && f <= 4'h6) begin
          ys = 1'b1;
          pc = (f == 4'h4) ? 1'b1 : (f == 4'h5) ? ~n : ~z;
        end
      end
    end
    return {pc, ir, acc, xs, ys, as_, fn, rd, wr, h};
  endfunction

  function automatic int nxt(input int st, input bit hu, input logic [3:0] f,
                             input logic rdy, input logic rst);
    if (!rst) return S_F;
    if (st == S_F) return rdy ? S_E : S_F;
    if (st == S_H) return S_H;
    if (f <= 4'h3) return rdy ? S_F : S_E;
    if (f <= 4'h6) return S_F;
    if (f == 4'h7) return S_H;
    return hu ? S_H : S_F;
  endfunction

  task automatic push(input string tag);
    sb_t s;
    s.tag = tag;
    s.e0  = exp_out(st0, F, N, Z, Mem_rdy, Reset);
    s.e1  = exp_out(st1, F, N, Z, Mem_rdy, Reset);
    sb_q.push_back(s);
  endtask

  task automatic pop_check();
    sb_t s;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      s = sb_q.pop_front();
      check({s.tag, "/u0"}, 32'(o0), 32'(s.e0));
      check({s.tag, "/u1"}, 32'(o1), 32'(s.e1));
    end
  endtask

  // Drive one cycle at the falling edge, check mid-cycle, advance the model.
  task automatic step(input string tag, input logic rst, input logic [3:0] f,
                      input logic n, input logic z, input logic rdy);
    @(negedge Clk);
    Reset = rst; F = f; N = n; Z = z; Mem_rdy = rdy;
    push(tag);
    #1;
    pop_check();
    st0 = nxt(st0, 1'b0, f, rdy, rst);
    st1 = nxt(st1, 1'b1, f, rdy, rst);
  endtask

  // Assert reset mid-cycle (no clock edge) to observe the asynchronous drop.
  task automatic async_reset(input string tag);
    #1;
    Reset = 1'b0;
    st0 = S_F;
    st1 = S_F;
    push(tag);
    #1;
    pop_check();
  endtask

  initial begin
    Reset = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0; Mem_rdy = 1'b1;
    #1;
    check("reset_t0", 32'({o0, o1}), 32'd0);

    step("rst_hold",  1'b0, 4'h0, 0, 0, 1);
    step("fetch_lda", 1'b1, 4'h0, 0, 0, 1);
    step("exec_lda",  1'b1, 4'h0, 0, 0, 1);
    // STO with two wait states
    step("fetch_sto", 1'b1, 4'h1, 0, 0, 1);
    step("sto_w0",    1'b1, 4'h1, 0, 0, 0);
    step("sto_w1",    1'b1, 4'h1, 0, 0, 0);
    step("sto_done",  1'b1, 4'h1, 0, 0, 1);
    // conditional jumps
    step("fetch_jge", 1'b1, 4'h5, 1, 0, 1);
    step("jge_n1",    1'b1, 4'h5, 1, 0, 1);
    step("fetch_jge", 1'b1, 4'h5, 0, 0, 1);
    step("jge_n0",    1'b1, 4'h5, 0, 0, 1);
    step("fetch_jne", 1'b1, 4'h6, 0, 1, 1);
    step("jne_z1",    1'b1, 4'h6, 0, 1, 1);
    step("fetch_jne", 1'b1, 4'h6, 0, 0, 1);
    step("jne_z0",    1'b1, 4'h6, 0, 0, 1);
    // ADD/SUB with a wait state, JMP ignoring Mem_rdy, fetch waits
    step("fetch_add", 1'b1, 4'h2, 0, 0, 1);
    step("add_w",     1'b1, 4'h2, 0, 0, 0);
    step("add_done",  1'b1, 4'h2, 0, 0, 1);
    step("fetch_w0",  1'b1, 4'h3, 0, 0, 0);
    step("fetch_w1",  1'b1, 4'h3, 0, 0, 0);
    step("fetch_sub", 1'b1, 4'h3, 0, 0, 1);
    step("sub_done",  1'b1, 4'h3, 0, 0, 1);
    step("fetch_jmp", 1'b1, 4'h4, 0, 0, 1);
    step("jmp_nordy", 1'b1, 4'h4, 0, 0, 0);
    // undefined opcode: NOP in u0, halt in u1
    step("fetch_undef", 1'b1, 4'hA, 0, 0, 1);
    step("exec_undef",  1'b1, 4'hA, 0, 0, 0);
    step("post_undef",  1'b1, 4'h7, 0, 0, 1);
    step("exec_stp",    1'b1, 4'h7, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step("halt_hold", 1'b1, 4'($urandom_range(0, 15)), 1'($urandom),
           1'($urandom), 1'(i % 2));
    end
    // recover from halt, then reset during a FETCH wait
    step("rst_halt",   1'b0, 4'h0, 0, 0, 1);
    step("restart",    1'b1, 4'h0, 0, 0, 0);
    step("fetch_wait", 1'b1, 4'h0, 0, 0, 0);
    async_reset("rst_mid_wait");
    step("rst_low",    1'b0, 4'h2, 0, 0, 1);
    step("after_rst",  1'b1, 4'h2, 0, 0, 1);
    step("exec_add",   1'b1, 4'h2, 0, 0, 1);
    step("fetch_end",  1'b1, 4'h0, 0, 0, 1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
